player_sprite_fetch: RTL and testbench
======================================

Name: player_sprite_fetch

Overview:
Pixel-pipeline stage directly upstream of the player palette lookup (9-bit index -> 4-bit RGB).
- From the VGA scan position and the latched player state, it generates the sprite ROM address.
- It captures the 9-bit colour index the ROM returns and presents a registered palette index plus a sprite_on (opaque) flag to the palette and colour mapper.
- It handles left/right mirroring and walk-cycle animation, with a fixed 3-cycle latency.

Parameters:
SPRITE_W, 32, sprite width in pixels
SPRITE_H, 48, sprite height in pixels
NUM_FRAMES, 4, walk-cycle frames stored back-to-back in ROM
FRAMES_PER_STEP, 6, video frames per animation step
ADDR_W, 13, ROM address width (must be >= clog2(NUM_FRAMES*SPRITE_W*SPRITE_H))
TRANSPARENT_IDX, 0, palette index treated as see-through

Ports:
Clk  in  1  system/pixel-enable clock
Reset  in  1  synchronous, active-high reset
frame_start  in  1  one-cycle pulse at start of vertical blank
blank  in  1  1 = active video at DrawX/DrawY
DrawX  in  10  current scan column, 0..639
DrawY  in  10  current scan row, 0..479
PlayerX  in  10  sprite left edge
PlayerY  in  10  sprite top edge
facing_left  in  1  1 = draw mirrored
moving  in  1  1 = player walking, animate
rom_addr  out  ADDR_W  registered address to the synchronous sprite ROM (1-cycle read)
rom_q  in  9  ROM data, valid one cycle after rom_addr
palette_index  out  9  registered index to the palette
sprite_on  out  1  palette_index is valid and opaque
blank_d  out  1  blank delayed 3 cycles, aligned with outputs

Behaviour:
- Reset values: all outputs 0. Latched position/facing regs 0, frame counter 0, anim frame 0, pipeline valid bits 0.
- Frame-latched state: on frame_start, capture PlayerX, PlayerY and facing_left into shadow regs. The drawn sprite never changes mid-frame.
- Animation:
  - frame_cnt increments on each frame_start.
  - When moving and frame_cnt == FRAMES_PER_STEP-1: frame_cnt <= 0 and anim <= (anim == NUM_FRAMES-1) ? 0 : anim+1.
  - When !moving at frame_start: anim <= 0 and frame_cnt <= 0.
  - Updates occur only on frame_start.
- Stage 1 (cycle N -> N+1):
  - hit = blank && DrawX >= sx && DrawX < sx+SPRITE_W && DrawY >= sy && DrawY < sy+SPRITE_H.
  - Comparisons use 11-bit sums, so sprites near x=639/y=479 clip without wraparound.
  - col = DrawX-sx; if facing_left, col = SPRITE_W-1-col. row = DrawY-sy.
  - rom_addr <= anim*SPRITE_W*SPRITE_H + row*SPRITE_W + col, truncated to ADDR_W.
  - rom_addr holds its previous value when !hit. v1 <= hit.
- Stage 2 (N+1 -> N+2): ROM registers the read; v2 <= v1.
- Stage 3 (N+2 -> N+3):
  - palette_index <= v2 ? rom_q : 0.
  - sprite_on <= v2 && (rom_q != TRANSPARENT_IDX).
- blank_d: blank delayed by 3 registers.
- Total latency: DrawX/DrawY at cycle N -> sprite_on/palette_index/blank_d at N+3. Throughput is 1 pixel/cycle, with no stalls.
- Simultaneous frame_start with an active pixel: the pixel in flight uses the old shadow regs; the new values apply from the next cycle.
- Reset mid-line: the pipeline flushes. sprite_on stays 0 for the first 3 cycles after Reset deasserts.
- Sprite fully off-screen (PlayerX >= 640): hit is never set and sprite_on stays 0.

Decomposition:
- Package sprite_pkg: DrawX/DrawY width (10), screen limits 640/480, TRANSPARENT_IDX default, anim_state typedef.
- Sub-module sprite_anim_ctrl: frame counter plus animation-frame FSM, output anim[clog2(NUM_FRAMES)-1:0]. The pixel pipeline stays in the top module.

Test Plan:
1. Reset, PlayerX=100, PlayerY=200, frame_start, facing_left=0; scan DrawX=100, DrawY=200 -> rom_addr=0 at N+1; with rom_q=0x05 at N+2, palette_index=5 and sprite_on=1 at N+3.
2. Same position, facing_left=1 after next frame_start; DrawX=100, DrawY=201 -> rom_addr=32+31=63. DrawX=131 -> rom_addr=32.
3. rom_q=TRANSPARENT_IDX (0) inside the sprite -> sprite_on=0 at N+3. DrawX=99 (outside) -> sprite_on=0 and palette_index=0 regardless of rom_q.
4. moving=1 for 6 frame_start pulses -> anim=1, and pixel (0,0) of the sprite gives rom_addr=1536. After 24 pulses anim wraps to 0. Dropping moving then one frame_start -> anim=0.
5. PlayerX=620, DrawX=639 -> hit (col 19). DrawX=0 on the same row -> no hit (no wraparound). Change PlayerX mid-frame -> rom_addr unchanged until the next frame_start.
6. Assert Reset for 1 cycle while a hit pixel is in flight -> sprite_on=0, palette_index=0, blank_d=0 for the next 3 cycles.

Source files
------------

// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sprite_pkg
// Brief    : Shared widths, screen limits and animation state encoding for the
//            player sprite fetch pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package sprite_pkg;

  // Scan coordinate width (DrawX/DrawY/PlayerX/PlayerY)
  localparam int c_coord_w = 10;

  // Visible screen extent
  localparam int c_screen_w = 640;
  localparam int c_screen_h = 480;

  // Palette index that lets the background show through
  localparam int c_transparent_idx = 0;

  // Walk-cycle controller state: idle keeps the standing frame, walk animates
  typedef enum logic [0:0] {
    ANIM_IDLE = 1'b0,
    ANIM_WALK = 1'b1
  } anim_state_t;

endpackage
`default_nettype wire

// File: rtl/player_sprite_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : player_sprite_fetch_if
// Brief    : Sprite ROM read bus. The fetch stage drives the address and the
//            synchronous ROM returns data one cycle later.
// Revision : 1.0 - initial release
// ============================================================================
interface player_sprite_fetch_if #(
  parameter int ADDR_W = 13
);

  logic [ADDR_W-1:0] rom_addr;
  logic [8:0]        rom_q;

  // Fetch stage side
  modport master (
    output rom_addr,
    input  rom_q
  );

  // ROM side
  modport slave (
    input  rom_addr,
    output rom_q
  );

endinterface
`default_nettype wire

// File: rtl/sprite_anim_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sprite_anim_ctrl
// Brief    : Video-frame counter and walk-cycle frame selector. Everything
//            advances only on frame_start so the sprite is stable per frame.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_anim_ctrl
  import sprite_pkg::*;
#(
  parameter int NUM_FRAMES      = 4,
  parameter int FRAMES_PER_STEP = 6,
  localparam int ANIM_W         = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_start,
  input  logic              moving,
  output logic [ANIM_W-1:0] anim
);

  localparam int c_cnt_w = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  anim_state_t        state_q, state_d;
  logic [c_cnt_w-1:0] frame_cnt_q, frame_cnt_d;
  logic [ANIM_W-1:0]  anim_q, anim_d;

  // State, frame counter and animation frame registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ANIM_IDLE;
      frame_cnt_q <= '0;
      anim_q      <= '0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      anim_q      <= anim_d;
    end
  end

  // Next state: stop snaps back to frame 0, walking steps every FRAMES_PER_STEP frames
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    anim_d      = anim_q;
    if (frame_start) begin
      if (!moving) begin
        state_d     = ANIM_IDLE;
        frame_cnt_d = '0;
        anim_d      = '0;
      end else begin
        state_d = ANIM_WALK;
        if (frame_cnt_q == c_cnt_w'(FRAMES_PER_STEP - 1)) begin
          frame_cnt_d = '0;
          anim_d      = (anim_q == ANIM_W'(NUM_FRAMES - 1)) ? '0 : anim_q + ANIM_W'(1);
        end else begin
          frame_cnt_d = frame_cnt_q + c_cnt_w'(1);
        end
      end
    end
  end

  // Idle always shows the standing frame
  assign anim = (state_q == ANIM_WALK) ? anim_q : '0;

endmodule
`default_nettype wire

// File: rtl/player_sprite_fetch.sv
`default_nettype none
// ============================================================================
// Module   : player_sprite_fetch
// Brief    : Three-stage pixel pipeline: hit test + ROM address, ROM read,
//            palette index capture. Handles mirroring and walk animation.
// Revision : 1.0 - initial release
// ============================================================================
module player_sprite_fetch
  import sprite_pkg::*;
#(
  parameter int SPRITE_W        = 32,
  parameter int SPRITE_H        = 48,
  parameter int NUM_FRAMES      = 4,
  parameter int FRAMES_PER_STEP = 6,
  parameter int ADDR_W          = 13,
  parameter int TRANSPARENT_IDX = c_transparent_idx
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 frame_start,
  input  logic                 blank,
  input  logic [c_coord_w-1:0] DrawX,
  input  logic [c_coord_w-1:0] DrawY,
  input  logic [c_coord_w-1:0] PlayerX,
  input  logic [c_coord_w-1:0] PlayerY,
  input  logic                 facing_left,
  input  logic                 moving,
  player_sprite_fetch_if.master rom_bus,
  output logic [8:0]           palette_index,
  output logic                 sprite_on,
  output logic                 blank_d
);

  localparam int c_anim_w = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

  logic [c_anim_w-1:0]  anim;

  logic [c_coord_w-1:0] sx_q, sx_d, sy_q, sy_d;
  logic                 face_q, face_d;
  logic [ADDR_W-1:0]    rom_addr_q, rom_addr_d;
  logic                 v1_q, v1_d, v2_q, v2_d;
  logic [8:0]           palette_index_q, palette_index_d;
  logic                 sprite_on_q, sprite_on_d;
  logic [2:0]           blank_pipe_q, blank_pipe_d;

  logic [c_coord_w:0]   x_ext, y_ext, sx_ext, sy_ext;
  logic [c_coord_w-1:0] col_raw, col, row;
  logic [ADDR_W-1:0]    addr_calc;
  logic                 hit;

  sprite_anim_ctrl #(
    .NUM_FRAMES      (NUM_FRAMES),
    .FRAMES_PER_STEP (FRAMES_PER_STEP)
  ) u_anim (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_start (frame_start),
    .moving      (moving),
    .anim        (anim)
  );

  // Shadow position/facing latched once per video frame
  always_comb begin
    sx_d   = sx_q;
    sy_d   = sy_q;
    face_d = face_q;
    if (frame_start) begin
      sx_d   = PlayerX;
      sy_d   = PlayerY;
      face_d = facing_left;
    end
  end

  // Pipeline stages: hit test and address, valid shift, palette capture
  always_comb begin
    // One extra bit keeps sx+SPRITE_W from wrapping near the right/bottom edge
    x_ext  = {1'b0, DrawX};
    y_ext  = {1'b0, DrawY};
    sx_ext = {1'b0, sx_q};
    sy_ext = {1'b0, sy_q};
    hit    = blank
          && (x_ext >= sx_ext) && (x_ext < sx_ext + (c_coord_w + 1)'(SPRITE_W))
          && (y_ext >= sy_ext) && (y_ext < sy_ext + (c_coord_w + 1)'(SPRITE_H));

    col_raw = DrawX - sx_q;
    col     = face_q ? (c_coord_w'(SPRITE_W - 1) - col_raw) : col_raw;
    row     = DrawY - sy_q;

    addr_calc = ADDR_W'(anim) * ADDR_W'(SPRITE_W * SPRITE_H)
              + ADDR_W'(row) * ADDR_W'(SPRITE_W)
              + ADDR_W'(col);

    // Address holds on misses so the ROM bus stays quiet off-sprite
    rom_addr_d = hit ? addr_calc : rom_addr_q;
    v1_d       = hit;
    v2_d       = v1_q;

    palette_index_d = v2_q ? rom_bus.rom_q : '0;
    sprite_on_d     = v2_q && (rom_bus.rom_q != 9'(TRANSPARENT_IDX));

    blank_pipe_d = {blank_pipe_q[1:0], blank};
  end

  // All datapath and control registers; reset flushes the pipeline
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sx_q            <= '0;
      sy_q            <= '0;
      face_q          <= 1'b0;
      rom_addr_q      <= '0;
      v1_q            <= 1'b0;
      v2_q            <= 1'b0;
      palette_index_q <= '0;
      sprite_on_q     <= 1'b0;
      blank_pipe_q    <= '0;
    end else begin
      sx_q            <= sx_d;
      sy_q            <= sy_d;
      face_q          <= face_d;
      rom_addr_q      <= rom_addr_d;
      v1_q            <= v1_d;
      v2_q            <= v2_d;
      palette_index_q <= palette_index_d;
      sprite_on_q     <= sprite_on_d;
      blank_pipe_q    <= blank_pipe_d;
    end
  end

  assign rom_bus.rom_addr = rom_addr_q;
  assign palette_index    = palette_index_q;
  assign sprite_on        = sprite_on_q;
  assign blank_d          = blank_pipe_q[2];

endmodule
`default_nettype wire

// File: tb/tb_player_sprite_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_player_sprite_fetch
// Brief    : Directed self-checking bench for player_sprite_fetch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_player_sprite_fetch;

  logic       Clk = 1'b0;
  logic       Reset, frame_start, blank, facing_left, moving;
  logic [9:0] DrawX, DrawY, PlayerX, PlayerY;
  logic [8:0] palette_index;
  logic       sprite_on, blank_d;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  logic [12:0] a;
  logic [8:0]  pal;
  logic        on, bd;

  player_sprite_fetch_if #(.ADDR_W(13)) rom_bus ();

  player_sprite_fetch dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .frame_start   (frame_start),
    .blank         (blank),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .PlayerX       (PlayerX),
    .PlayerY       (PlayerY),
    .facing_left   (facing_left),
    .moving        (moving),
    .rom_bus       (rom_bus),
    .palette_index (palette_index),
    .sprite_on     (sprite_on),
    .blank_d       (blank_d)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic new_frame(input logic [9:0] px, input logic [9:0] py, input logic face, input logic mov);
    PlayerX = px; PlayerY = py; facing_left = face; moving = mov;
    frame_start = 1'b1; blank = 1'b0;
    tick();
    frame_start = 1'b0;
  endtask

  // Drives one pixel, returns rom_addr at N+1 and the outputs at N+3
  task automatic run_pixel(input logic [9:0] x, input logic [9:0] y, input logic b, input logic [8:0] q);
    DrawX = x; DrawY = y; blank = b;
    tick();
    frame_start = 1'b0;
    a = rom_bus.rom_addr;
    blank = 1'b0;
    tick();
    rom_bus.rom_q = q;
    tick();
    pal = palette_index; on = sprite_on; bd = blank_d;
    rom_bus.rom_q = 9'd0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick(); tick();
    assert_cnt++; if (rom_bus.rom_addr !== 13'd0) begin fail_cnt++; $display("FAIL reset_addr: got %0d expected 0", rom_bus.rom_addr); end
    assert_cnt++; if (palette_index !== 9'd0) begin fail_cnt++; $display("FAIL reset_pal: got %0d expected 0", palette_index); end
    assert_cnt++; if (sprite_on !== 1'b0) begin fail_cnt++; $display("FAIL reset_on: got %0b expected 0", sprite_on); end
    assert_cnt++; if (blank_d !== 1'b0) begin fail_cnt++; $display("FAIL reset_blank_d: got %0b expected 0", blank_d); end
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    new_frame(10'd100, 10'd200, 1'b0, 1'b0);
    run_pixel(10'd100, 10'd200, 1'b1, 9'h005);
    assert_cnt++; if (a !== 13'd0) begin fail_cnt++; $display("FAIL basic_addr: got %0d expected 0", a); end
    assert_cnt++; if (pal !== 9'd5) begin fail_cnt++; $display("FAIL basic_pal: got %0d expected 5", pal); end
    assert_cnt++; if (on !== 1'b1) begin fail_cnt++; $display("FAIL basic_on: got %0b expected 1", on); end
    assert_cnt++; if (bd !== 1'b1) begin fail_cnt++; $display("FAIL basic_blank_d: got %0b expected 1", bd); end
    run_pixel(10'd101, 10'd200, 1'b1, 9'h005);
    assert_cnt++; if (a !== 13'd1) begin fail_cnt++; $display("FAIL basic_addr_col1: got %0d expected 1", a); end
    run_pixel(10'd100, 10'd247, 1'b1, 9'h010);
    assert_cnt++; if (a !== 13'd1504) begin fail_cnt++; $display("FAIL basic_last_row_addr: got %0d expected 1504", a); end
    assert_cnt++; if (on !== 1'b1) begin fail_cnt++; $display("FAIL basic_last_row_on: got %0b expected 1", on); end
    run_pixel(10'd100, 10'd248, 1'b1, 9'h010);
    assert_cnt++; if (on !== 1'b0 || pal !== 9'd0) begin fail_cnt++; $display("FAIL basic_below_out: got on=%0b pal=%0d expected on=0 pal=0", on, pal); end
    assert_cnt++; if (a !== 13'd1504) begin fail_cnt++; $display("FAIL basic_addr_hold: got %0d expected 1504", a); end
  endtask

  task automatic test_mirror();
    new_frame(10'd100, 10'd200, 1'b1, 1'b0);
    run_pixel(10'd100, 10'd201, 1'b1, 9'h022);
    assert_cnt++; if (a !== 13'd63) begin fail_cnt++; $display("FAIL mirror_left_edge: got %0d expected 63", a); end
    run_pixel(10'd131, 10'd201, 1'b1, 9'h1FF);
    assert_cnt++; if (a !== 13'd32) begin fail_cnt++; $display("FAIL mirror_right_edge: got %0d expected 32", a); end
    assert_cnt++; if (pal !== 9'h1FF || on !== 1'b1) begin fail_cnt++; $display("FAIL mirror_out: got pal=%0h on=%0b expected pal=1ff on=1", pal, on); end
  endtask

  task automatic test_transparent();
    run_pixel(10'd100, 10'd201, 1'b1, 9'h000);
    assert_cnt++; if (on !== 1'b0 || pal !== 9'd0) begin fail_cnt++; $display("FAIL transp_in: got on=%0b pal=%0d expected on=0 pal=0", on, pal); end
    assert_cnt++; if (bd !== 1'b1) begin fail_cnt++; $display("FAIL transp_blank_d: got %0b expected 1", bd); end
    run_pixel(10'd99, 10'd201, 1'b1, 9'h1AB);
    assert_cnt++; if (on !== 1'b0 || pal !== 9'd0) begin fail_cnt++; $display("FAIL transp_outside: got on=%0b pal=%0h expected on=0 pal=0", on, pal); end
    assert_cnt++; if (a !== 13'd63) begin fail_cnt++; $display("FAIL transp_addr_hold: got %0d expected 63", a); end
    run_pixel(10'd110, 10'd210, 1'b0, 9'h033);
    assert_cnt++; if (on !== 1'b0 || pal !== 9'd0 || bd !== 1'b0) begin fail_cnt++; $display("FAIL transp_blanked: got on=%0b pal=%0h bd=%0b expected 0 0 0", on, pal, bd); end
  endtask

  task automatic test_anim();
    for (int i = 0; i < 6; i++) new_frame(10'd100, 10'd200, 1'b0, 1'b1);
    run_pixel(10'd100, 10'd200, 1'b1, 9'h001);
    assert_cnt++; if (a !== 13'd1536) begin fail_cnt++; $display("FAIL anim_step1: got %0d expected 1536", a); end
    for (int i = 0; i < 6; i++) new_frame(10'd100, 10'd200, 1'b0, 1'b1);
    run_pixel(10'd100, 10'd200, 1'b1, 9'h001);
    assert_cnt++; if (a !== 13'd3072) begin fail_cnt++; $display("FAIL anim_step2: got %0d expected 3072", a); end
    for (int i = 0; i < 11; i++) new_frame(10'd100, 10'd200, 1'b0, 1'b1);
    run_pixel(10'd100, 10'd200, 1'b1, 9'h001);
    assert_cnt++; if (a !== 13'd4608) begin fail_cnt++; $display("FAIL anim_step3_pulse23: got %0d expected 4608", a); end
    new_frame(10'd100, 10'd200, 1'b0, 1'b1);
    run_pixel(10'd101, 10'd201, 1'b1, 9'h001);
    assert_cnt++; if (a !== 13'd33) begin fail_cnt++; $display("FAIL anim_wrap: got %0d expected 33", a); end
    for (int i = 0; i < 6; i++) new_frame(10'd100, 10'd200, 1'b0, 1'b1);
    run_pixel(10'd102, 10'd200, 1'b1, 9'h001);
    assert_cnt++; if (a !== 13'd1538) begin fail_cnt++; $display("FAIL anim_again1: got %0d expected 1538", a); end
    new_frame(10'd100, 10'd200, 1'b0, 1'b0);
    run_pixel(10'd102, 10'd200, 1'b1, 9'h001);
    assert_cnt++; if (a !== 13'd2) begin fail_cnt++; $display("FAIL anim_stop: got %0d expected 2", a); end
    for (int i = 0; i < 3; i++) new_frame(10'd100, 10'd200, 1'b0, 1'b1);
    run_pixel(10'd103, 10'd200, 1'b1, 9'h001);
    assert_cnt++; if (a !== 13'd3) begin fail_cnt++; $display("FAIL anim_cnt_cleared: got %0d expected 3", a); end
    for (int i = 0; i < 3; i++) new_frame(10'd100, 10'd200, 1'b0, 1'b1);
    run_pixel(10'd104, 10'd200, 1'b1, 9'h001);
    assert_cnt++; if (a !== 13'd1540) begin fail_cnt++; $display("FAIL anim_restart: got %0d expected 1540", a); end
  endtask

  task automatic test_clip();
    new_frame(10'd620, 10'd200, 1'b0, 1'b0);
    run_pixel(10'd639, 10'd200, 1'b1, 9'h007);
    assert_cnt++; if (a !== 13'd19) begin fail_cnt++; $display("FAIL clip_right_addr: got %0d expected 19", a); end
    assert_cnt++; if (on !== 1'b1 || pal !== 9'd7) begin fail_cnt++; $display("FAIL clip_right_out: got on=%0b pal=%0d expected on=1 pal=7", on, pal); end
    run_pixel(10'd0, 10'd200, 1'b1, 9'h007);
    assert_cnt++; if (on !== 1'b0 || pal !== 9'd0 || a !== 13'd19) begin fail_cnt++; $display("FAIL clip_no_wrap: got on=%0b pal=%0d addr=%0d expected 0 0 19", on, pal, a); end
    PlayerX = 10'd300;
    run_pixel(10'd639, 10'd201, 1'b1, 9'h008);
    assert_cnt++; if (a !== 13'd51 || on !== 1'b1) begin fail_cnt++; $display("FAIL clip_midframe_move: got addr=%0d on=%0b expected 51 1", a, on); end
    frame_start = 1'b1;
    run_pixel(10'd639, 10'd202, 1'b1, 9'h008);
    assert_cnt++; if (a !== 13'd83 || on !== 1'b1) begin fail_cnt++; $display("FAIL clip_same_cycle_frame_start: got addr=%0d on=%0b expected 83 1", a, on); end
    run_pixel(10'd301, 10'd200, 1'b1, 9'h008);
    assert_cnt++; if (a !== 13'd1 || on !== 1'b1) begin fail_cnt++; $display("FAIL clip_new_position: got addr=%0d on=%0b expected 1 1", a, on); end
    new_frame(10'd640, 10'd200, 1'b0, 1'b0);
    run_pixel(10'd639, 10'd200, 1'b1, 9'h008);
    assert_cnt++; if (on !== 1'b0 || a !== 13'd1) begin fail_cnt++; $display("FAIL clip_offscreen: got on=%0b addr=%0d expected 0 1", on, a); end
  endtask

  task automatic test_reset_flight();
    new_frame(10'd0, 10'd0, 1'b0, 1'b0);
    DrawX = 10'd5; DrawY = 10'd5; blank = 1'b1; rom_bus.rom_q = 9'd9;
    tick(); tick(); tick();
    assert_cnt++; if (sprite_on !== 1'b1) begin fail_cnt++; $display("FAIL flight_before_reset: got %0b expected 1", sprite_on); end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      assert_cnt++;
      if (sprite_on !== 1'b0 || palette_index !== 9'd0 || blank_d !== 1'b0) begin
        fail_cnt++;
        $display("FAIL flight_flush_cycle%0d: got on=%0b pal=%0d bd=%0b expected 0 0 0", i, sprite_on, palette_index, blank_d);
      end
      tick();
    end
    assert_cnt++; if (sprite_on !== 1'b1 || palette_index !== 9'd9 || blank_d !== 1'b1) begin fail_cnt++; $display("FAIL flight_refill: got on=%0b pal=%0d bd=%0b expected 1 9 1", sprite_on, palette_index, blank_d); end
    assert_cnt++; if (rom_bus.rom_addr !== 13'd165) begin fail_cnt++; $display("FAIL flight_addr: got %0d expected 165", rom_bus.rom_addr); end
    blank = 1'b0; rom_bus.rom_q = 9'd0;
    tick();
  endtask

  initial begin
    Reset = 1'b1; frame_start = 1'b0; blank = 1'b0; facing_left = 1'b0; moving = 1'b0;
    DrawX = '0; DrawY = '0; PlayerX = '0; PlayerY = '0;
    rom_bus.rom_q = 9'd0;
    test_reset();
    test_basic();
    test_mirror();
    test_transparent();
    test_anim();
    test_clip();
    test_reset_flight();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
